alu_issue_stage: RTL and testbench

//  Decode-to-execute issue stage placed directly upstream of the ALU. Accepts decoded ops

---
 rtl/alu_issue_pkg.sv | 20 ++
 rtl/issue_skid.sv | 47 ++++
 rtl/alu_issue_stage.sv | 135 +++++++++++++
 tb/tb_alu_issue_stage.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_issue_pkg.sv
// Shared ALU issue definitions: default widths and ALU opcode codes.
package alu_issue_pkg;

  localparam int ALU_DATA_W = 32;
  localparam int ALU_REG_AW = 5;
  localparam int ALU_OP_W   = 5;

  typedef enum logic [ALU_OP_W-1:0] {
    ALUOP_ADD = 5'd0,
    ALUOP_SUB = 5'd1,
    ALUOP_AND = 5'd2,
    ALUOP_OR  = 5'd3,
    ALUOP_XOR = 5'd4,
    ALUOP_SHL = 5'd5,
    ALUOP_SHR = 5'd6,
    ALUOP_DIV = 5'd7,
    ALUOP_SLT = 5'd8
  } aluop_e;

endpackage

// File: rtl/issue_skid.sv
// One-entry skid register. The input is ready whenever the entry is empty, so
// in_ready is a pure register output. While the entry is empty the input passes
// straight through to the output side.
module issue_skid #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         full_q, full_d;
  logic [W-1:0] data_q, data_d;

  assign in_ready  = !full_q;
  assign out_valid = full_q || in_valid;
  assign out_data  = full_q ? data_q : in_data;

  // Park an accepted item when the consumer stalls; release it on out_ready.
  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (full_q) begin
      if (out_ready) full_d = 1'b0;
    end else if (in_valid && !out_ready) begin
      full_d = 1'b1;
      data_d = in_data;
    end
  end

  // Skid state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Decode-to-execute issue stage: operand resolve with ALU bypass, shift-amount
// mask, registered ALU bundle, one-entry skid so dec_ready is registered.
// Optional ALU_ISSUE_DIV0_TRAP_EN: drop DIV-by-zero ops and pulse ex_trap.
module alu_issue_stage
  import alu_issue_pkg::*;
#(
  parameter int DATA_W = ALU_DATA_W,
  parameter int REG_AW = ALU_REG_AW,
  parameter int OP_W   = ALU_OP_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dec_valid,
  output logic              dec_ready,
  input  logic [OP_W-1:0]   dec_aluOp,
  input  logic [REG_AW-1:0] dec_rd,
  input  logic [REG_AW-1:0] dec_rs1,
  input  logic [REG_AW-1:0] dec_rs2,
  input  logic              dec_useImm,
  input  logic [DATA_W-1:0] dec_imm,
  input  logic [DATA_W-1:0] rs1_data,
  input  logic [DATA_W-1:0] rs2_data,
  input  logic [DATA_W-1:0] fwd_data,
  output logic              ex_valid,
  input  logic              ex_ready,
  output logic [OP_W-1:0]   ex_aluOp,
  output logic [DATA_W-1:0] ex_in1,
  output logic [DATA_W-1:0] ex_in2,
  output logic [REG_AW-1:0] ex_rd,
  output logic              ex_trap
);

  localparam int PW = OP_W + 2*DATA_W + REG_AW + 1;

  logic [DATA_W-1:0] op1, op2, in2_sel, in2_fin;
  logic              trap_det;
  logic              s_ready, s_valid, load;
  logic [PW-1:0]     s_in, s_out;
  logic [OP_W-1:0]   s_op;
  logic [DATA_W-1:0] s_in1, s_in2;
  logic [REG_AW-1:0] s_rd;
  logic              s_trap;

  logic              ex_valid_q, ex_valid_d;
  logic [OP_W-1:0]   ex_op_q, ex_op_d;
  logic [DATA_W-1:0] ex_in1_q, ex_in1_d, ex_in2_q, ex_in2_d;
  logic [REG_AW-1:0] ex_rd_q, ex_rd_d;
  logic              ex_trap_q, ex_trap_d;

  // Operand resolve: r0 is zero, then bypass from the op held in ex_*, then regfile.
  always_comb begin
    op1 = rs1_data;
    if (dec_rs1 == '0) op1 = '0;
    else if (ex_valid_q && dec_rs1 == ex_rd_q) op1 = fwd_data;
    op2 = rs2_data;
    if (dec_rs2 == '0) op2 = '0;
    else if (ex_valid_q && dec_rs2 == ex_rd_q) op2 = fwd_data;
    in2_sel = dec_useImm ? dec_imm : op2;
    in2_fin = in2_sel;
    if (dec_aluOp == OP_W'(ALUOP_SHL) || dec_aluOp == OP_W'(ALUOP_SHR))
      in2_fin = {{(DATA_W-5){1'b0}}, in2_sel[4:0]};
  end

`ifdef ALU_ISSUE_DIV0_TRAP_EN
  assign trap_det = (dec_aluOp == OP_W'(ALUOP_DIV)) && (in2_fin == '0);
`else
  assign trap_det = 1'b0;
`endif

  // Operands are resolved before the skid, so a parked op keeps the bypass
  // value seen while the stalled ex_* op was stable.
  assign s_in = {dec_aluOp, op1, in2_fin, dec_rd, trap_det};
  assign load = !ex_valid_q || ex_ready;

  issue_skid #(.W(PW)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (dec_valid),
    .in_ready  (s_ready),
    .in_data   (s_in),
    .out_valid (s_valid),
    .out_ready (load),
    .out_data  (s_out)
  );

  assign {s_op, s_in1, s_in2, s_rd, s_trap} = s_out;
  assign dec_ready = s_ready;

  // Output register next state: load when free or draining, else hold.
  always_comb begin
    ex_valid_d = ex_valid_q;
    ex_op_d    = ex_op_q;
    ex_in1_d   = ex_in1_q;
    ex_in2_d   = ex_in2_q;
    ex_rd_d    = ex_rd_q;
    ex_trap_d  = 1'b0;
    if (load) begin
      ex_valid_d = s_valid && !s_trap;
      ex_trap_d  = s_valid && s_trap;
      if (s_valid && !s_trap) begin
        ex_op_d  = s_op;
        ex_in1_d = s_in1;
        ex_in2_d = s_in2;
        ex_rd_d  = s_rd;
      end
    end
  end

  // Output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid_q <= 1'b0;
      ex_op_q    <= '0;
      ex_in1_q   <= '0;
      ex_in2_q   <= '0;
      ex_rd_q    <= '0;
      ex_trap_q  <= 1'b0;
    end else begin
      ex_valid_q <= ex_valid_d;
      ex_op_q    <= ex_op_d;
      ex_in1_q   <= ex_in1_d;
      ex_in2_q   <= ex_in2_d;
      ex_rd_q    <= ex_rd_d;
      ex_trap_q  <= ex_trap_d;
    end
  end

  assign ex_valid = ex_valid_q;
  assign ex_aluOp = ex_op_q;
  assign ex_in1   = ex_in1_q;
  assign ex_in2   = ex_in2_q;
  assign ex_rd    = ex_rd_q;
  assign ex_trap  = ex_trap_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Randomized + directed bench for alu_issue_stage with a queue-based reference model.
module tb_alu_issue_stage;
  import alu_issue_pkg::*;

`ifdef ALU_ISSUE_DIV0_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        dec_valid = 1'b0, dec_ready;
  logic [4:0]  dec_aluOp = '0, dec_rd = '0, dec_rs1 = '0, dec_rs2 = '0;
  logic        dec_useImm = 1'b0;
  logic [31:0] dec_imm = '0, rs1_data = '0, rs2_data = '0, fwd_data = '0;
  logic        ex_valid, ex_ready = 1'b1, ex_trap;
  logic [4:0]  ex_aluOp, ex_rd;
  logic [31:0] ex_in1, ex_in2;

  int checks = 0;
  int errors = 0;

  alu_issue_stage dut (
    .clk(clk), .rst(rst),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_aluOp(dec_aluOp),
    .dec_rd(dec_rd), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .dec_useImm(dec_useImm), .dec_imm(dec_imm),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .fwd_data(fwd_data),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_aluOp(ex_aluOp),
    .ex_in1(ex_in1), .ex_in2(ex_in2), .ex_rd(ex_rd), .ex_trap(ex_trap)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [4:0]  op;
    logic [31:0] in1, in2;
    logic [4:0]  rd;
    bit          trap;
  } op_t;

  op_t  pend[$];     // accepted but not yet in the output slot
  op_t  m_ex, m_n;
  bit   m_ex_v = 0, m_trap = 0;

  function automatic logic [31:0] rv(input logic [4:0] idx, input logic [31:0] d);
    if (idx == 0) return 32'd0;
    if (m_ex_v && m_ex.rd == idx) return fwd_data;
    return d;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pend.delete();
      m_ex_v = 0;
      m_trap = 0;
      m_ex   = '{op: 0, in1: 0, in2: 0, rd: 0, trap: 0};
    end else begin
      if (dec_valid && pend.size() == 0) begin
        m_n.op  = dec_aluOp;
        m_n.rd  = dec_rd;
        m_n.in1 = rv(dec_rs1, rs1_data);
        m_n.in2 = dec_useImm ? dec_imm : rv(dec_rs2, rs2_data);
        if (dec_aluOp == ALUOP_SHL || dec_aluOp == ALUOP_SHR) m_n.in2 = m_n.in2 % 32;
        m_n.trap = TRAP_EN && dec_aluOp == ALUOP_DIV && m_n.in2 == 0;
        pend.push_back(m_n);
      end
      m_trap = 0;
      if (!m_ex_v || ex_ready) begin
        if (pend.size() > 0) begin
          m_n = pend.pop_front();
          if (m_n.trap) begin
            m_ex_v = 0;
            m_trap = 1;
          end else begin
            m_ex_v = 1;
            m_ex   = m_n;
          end
        end else m_ex_v = 0;
      end
    end
  end

  // Compare DUT with model every cycle, away from the active edge.
  always @(negedge clk) begin
    chk("dec_ready", dec_ready, pend.size() == 0);
    chk("ex_valid", ex_valid, m_ex_v);
    chk("ex_trap", ex_trap, m_trap);
    if (m_ex_v) begin
      chk("ex_aluOp", ex_aluOp, m_ex.op);
      chk("ex_in1", ex_in1, m_ex.in1);
      chk("ex_in2", ex_in2, m_ex.in2);
      chk("ex_rd", ex_rd, m_ex.rd);
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] op, input logic [4:0] rd,
                       input logic [4:0] r1, input logic [4:0] r2, input logic ui,
                       input logic [31:0] imm, input logic [31:0] d1, input logic [31:0] d2,
                       input logic [31:0] fw);
    dec_valid = v; dec_aluOp = op; dec_rd = rd; dec_rs1 = r1; dec_rs2 = r2;
    dec_useImm = ui; dec_imm = imm; rs1_data = d1; rs2_data = d2; fwd_data = fw;
  endtask

  aluop_e ops[9] = '{ALUOP_ADD, ALUOP_SUB, ALUOP_AND, ALUOP_OR, ALUOP_XOR,
                     ALUOP_SHL, ALUOP_SHR, ALUOP_DIV, ALUOP_SLT};

  initial begin
    cyc(); cyc();
    chk("rst_ex_valid", ex_valid, 0);
    chk("rst_dec_ready", dec_ready, 1);
    rst = 1'b0;
    cyc();

    // Plain ADD, regfile operands
    ex_ready = 1;
    drive(1, ALUOP_ADD, 3, 1, 2, 0, 0, 5, 7, 32'hdead);
    cyc();
    chk("t2_valid", ex_valid, 1);
    chk("t2_op", ex_aluOp, ALUOP_ADD);
    chk("t2_in1", ex_in1, 5);
    chk("t2_in2", ex_in2, 7);
    chk("t2_rd", ex_rd, 3);

    // Bypass from ADD rd=3; rs1=0 is zero even when ex_rd=0
    drive(1, ALUOP_SUB, 4, 3, 0, 0, 0, 0, 9, 12);
    cyc();
    chk("t3_fwd_in1", ex_in1, 12);
    chk("t3_r0_in2", ex_in2, 0);
    drive(1, ALUOP_ADD, 0, 1, 2, 0, 0, 9, 1, 33);
    cyc();
    chk("t3_rd0", ex_rd, 0);
    drive(1, ALUOP_OR, 2, 0, 0, 0, 0, 55, 66, 99);
    cyc();
    chk("t3_r0_in1", ex_in1, 0);

    // Stall with two ops: first held, second parked in skid
    drive(0, ALUOP_ADD, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc();
    ex_ready = 0;
    drive(1, ALUOP_ADD, 5, 1, 2, 0, 0, 32'h11, 32'h22, 32'h1);
    cyc();
    chk("t4_a_in1", ex_in1, 32'h11);
    drive(1, ALUOP_SUB, 6, 5, 0, 0, 0, 32'h0, 32'h0, 32'h77);
    cyc();
    chk("t4_ready0", dec_ready, 0);
    chk("t4_hold_rd", ex_rd, 5);
    drive(0, ALUOP_ADD, 0, 0, 0, 0, 0, 0, 0, 32'h5555);
    cyc();
    chk("t4_hold_in1", ex_in1, 32'h11);
    ex_ready = 1;
    cyc();
    chk("t4_b_rd", ex_rd, 6);
    chk("t4_b_in1", ex_in1, 32'h77);
    chk("t4_ready1", dec_ready, 1);
    cyc();
    chk("t4_nodup", ex_valid, 0);

    // Shift amount mask vs plain pass-through
    drive(1, ALUOP_SHL, 7, 1, 2, 1, 32'h123, 1, 2, 3);
    cyc();
    chk("t5_shl_in2", ex_in2, 32'h3);
    drive(1, ALUOP_AND, 7, 1, 2, 1, 32'h123, 1, 2, 3);
    cyc();
    chk("t5_and_in2", ex_in2, 32'h123);

    // Divide by zero
    drive(0, ALUOP_ADD, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc();
    drive(1, ALUOP_DIV, 7, 1, 2, 0, 0, 40, 0, 0);
    cyc();
`ifdef ALU_ISSUE_DIV0_TRAP_EN
    chk("t6_trap", ex_trap, 1);
    chk("t6_valid", ex_valid, 0);
    drive(1, ALUOP_ADD, 8, 1, 2, 0, 0, 3, 4, 0);
    cyc();
    chk("t6_next_valid", ex_valid, 1);
    chk("t6_next_rd", ex_rd, 8);
    chk("t6_trap_clr", ex_trap, 0);
`else
    chk("t6_trap", ex_trap, 0);
    chk("t6_valid", ex_valid, 1);
    chk("t6_in2", ex_in2, 0);
`endif

    // Randomized traffic with dense register hazards
    for (int i = 0; i < 2000; i++) begin
      drive($urandom_range(0, 9) < 7, ops[$urandom_range(0, 8)],
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            $urandom_range(0, 3) == 0,
            ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom,
            $urandom,
            ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom,
            $urandom);
      ex_ready = $urandom_range(0, 9) < 6;
      cyc();
    end

    // Reset while the output register and skid are both full
    ex_ready = 0;
    drive(1, ALUOP_XOR, 9, 1, 2, 0, 0, 32'hffff, 32'h1234, 0);
    cyc();
    drive(1, ALUOP_OR, 10, 1, 2, 0, 0, 32'h1, 32'h2, 0);
    cyc();
    cyc();
    rst = 1;
    drive(0, ALUOP_ADD, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc();
    chk("t1_valid", ex_valid, 0);
    chk("t1_in1", ex_in1, 0);
    chk("t1_op", ex_aluOp, 0);
    chk("t1_ready", dec_ready, 1);
    chk("t1_trap", ex_trap, 0);
    rst = 0;
    ex_ready = 1;
    cyc();
    cyc();
    chk("t1_noreplay", ex_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
